// File: rtl/cmp_mon_pkg.sv
// Shared types and constants for the comparator result monitor.
// Flag codes are packed as {et, gt, lt}.
package cmp_mon_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StTrack = 2'd1,
        StAlarm = 2'd2
    } state_e;

    localparam int unsigned STREAK_W = 4;
    localparam logic [STREAK_W-1:0] STREAK_MAX = 4'hF;

    localparam logic [2:0] ET_CODE = 3'b100;
    localparam logic [2:0] GT_CODE = 3'b010;
    localparam logic [2:0] LT_CODE = 3'b001;

    function automatic logic is_one_hot(input logic [2:0] flags);
        return (flags == ET_CODE) || (flags == GT_CODE) || (flags == LT_CODE);
    endfunction

endpackage

// File: rtl/compare_result_monitor_sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping; synchronous clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/compare_result_monitor.sv
// Monitors comparator flag samples: per-outcome counts, consecutive-GT streak alarm with
// backpressure until acknowledged, and a sticky error for non-one-hot samples.
module compare_result_monitor
    import cmp_mon_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned STREAK_N = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                et,
    input  logic                gt,
    input  logic                lt,
    output logic                in_ready,
    input  logic                clr,
    input  logic                alarm_ack,
    output logic [CNT_W-1:0]    et_cnt,
    output logic [CNT_W-1:0]    gt_cnt,
    output logic [CNT_W-1:0]    lt_cnt,
    output logic [STREAK_W-1:0] streak,
    output logic                alarm,
    output logic                err
);

    state_e              state_q;
    logic [STREAK_W-1:0] streak_q;
    logic                alarm_q;
    logic                err_q;

    logic [2:0]          flags;
    logic                legal;
    logic                accept;
    logic                ack;
    logic                inc_et;
    logic                inc_gt;
    logic                inc_lt;
    logic [STREAK_W-1:0] streak_inc;

    assign flags = {et, gt, lt};

    // clr discards any sample offered in the same cycle.
    always_comb begin
        in_ready   = (state_q != StAlarm);
        accept     = in_valid && in_ready && !clr;
        legal      = is_one_hot(flags);
        ack        = alarm_ack && (state_q == StAlarm) && !clr;
        inc_et     = accept && (flags == ET_CODE);
        inc_gt     = accept && (flags == GT_CODE);
        inc_lt     = accept && (flags == LT_CODE);
        streak_inc = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            streak_q <= '0;
            alarm_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (clr) begin
            state_q  <= StIdle;
            streak_q <= '0;
            alarm_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (ack) begin
            state_q  <= StTrack;
            streak_q <= '0;
            alarm_q  <= 1'b0;
        end else if (accept) begin
            if (inc_gt) begin
                streak_q <= streak_inc;
                if (streak_inc == STREAK_W'(STREAK_N)) begin
                    state_q <= StAlarm;
                    alarm_q <= 1'b1;
                end else begin
                    state_q <= StTrack;
                    alarm_q <= 1'b0;
                end
            end else begin
                state_q  <= StTrack;
                streak_q <= '0;
                alarm_q  <= 1'b0;
            end
            if (!legal) begin
                err_q <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_et_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (inc_et),
        .count (et_cnt)
    );

    sat_counter #(.W(CNT_W)) u_gt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (inc_gt),
        .count (gt_cnt)
    );

    sat_counter #(.W(CNT_W)) u_lt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (inc_lt),
        .count (lt_cnt)
    );

    assign streak = streak_q;
    assign alarm  = alarm_q;
    assign err    = err_q;

endmodule
